// File: rtl/dispatch_buffer.sv
// Consumer end of the decode->dispatch interface: an in-order FIFO of dispatchable
// instructions with a valid/ready output, HALT intake freeze and a synchronous flush.
module dispatch_buffer #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [5:0]        dec_opcode,
  input  logic [INST_W-1:0] dec_inst,
  input  logic              dec_writeRd,
  input  logic              dec_RegDest,
  input  logic              dec_isDispatch,
  input  logic              dec_mem_wen,
  output logic              dsp_valid,
  input  logic              dsp_ready,
  output logic [5:0]        dsp_opcode,
  output logic [INST_W-1:0] dsp_inst,
  output logic              dsp_writeRd,
  output logic              dsp_RegDest,
  output logic              dsp_mem_wen,
  output logic [PTR_W:0]    count,
  output logic [PTR_W:0]    store_count,
  output logic              halted
);

  localparam logic [0:0]       ST_RUN    = 1'b0;
  localparam logic [0:0]       ST_HALTED = 1'b1;
  localparam logic [5:0]       OP_HALT   = 6'b110001;
  localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);

  logic [5:0]        op_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [2:0]        ctl_mem  [DEPTH];  // {writeRd, RegDest, mem_wen}

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   store_q, store_d;
  logic [0:0]       state_q, state_d;

  logic enq;
  logic deq;
  logic st_inc;
  logic st_dec;

  assign dec_ready = (state_q == ST_RUN) && (count_q != FULL) && !flush;
  assign enq       = dec_valid && dec_ready && dec_isDispatch;
  // A flush discards any same-cycle dequeue along with everything else.
  assign deq       = dsp_valid && dsp_ready && !flush;
  assign st_inc    = enq && dec_mem_wen;
  assign st_dec    = deq && ctl_mem[rd_ptr_q][0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    store_d  = store_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      store_d  = '0;
      state_d  = ST_RUN;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      case ({st_inc, st_dec})
        2'b10:   store_d = store_q + CNT_ONE;
        2'b01:   store_d = store_q - CNT_ONE;
        default: store_d = store_q;
      endcase
      if (enq && (dec_opcode == OP_HALT)) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      store_q  <= '0;
      state_q  <= ST_RUN;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      store_q  <= store_d;
      state_q  <= state_d;
    end
  end

  // Storage needs no reset: dsp_* outputs are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      op_mem[wr_ptr_q]   <= dec_opcode;
      inst_mem[wr_ptr_q] <= dec_inst;
      ctl_mem[wr_ptr_q]  <= {dec_writeRd, dec_RegDest, dec_mem_wen};
    end
  end

  assign dsp_valid   = (count_q != '0);
  assign dsp_opcode  = dsp_valid ? op_mem[rd_ptr_q]      : '0;
  assign dsp_inst    = dsp_valid ? inst_mem[rd_ptr_q]    : '0;
  assign dsp_writeRd = dsp_valid && ctl_mem[rd_ptr_q][2];
  assign dsp_RegDest = dsp_valid && ctl_mem[rd_ptr_q][1];
  assign dsp_mem_wen = dsp_valid && ctl_mem[rd_ptr_q][0];
  assign count       = count_q;
  assign store_count = store_q;
  assign halted      = (state_q == ST_HALTED);

endmodule
